axi_bresp_merge: RTL

//  Write-response merge stage on the memory side of the AXI MMU wrapper, directly upstream of axi_bresp_ch.
//  The AW path splits one master write into N slave bursts (page crossing) and pushes {id, N} per split.

---
 rtl/axi_bresp_merge_if.sv | 50 +++++
 rtl/axi_bresp_merge.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/axi_bresp_merge_if.sv
// ----------------------------------------------------------------------------
// axi_bresp_merge_if : split-command, slave-B and merged-B channel bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface axi_bresp_merge_if #(
  parameter int CNT_W = 4
);
  logic [3:0]       in_cid;
  logic [CNT_W-1:0] in_ccnt;
  logic             in_cvalid;
  logic             out_cready;

  logic [3:0]       in_mbid;
  logic [1:0]       in_mbresp;
  logic [1:0]       in_mbuser;
  logic             in_mbvalid;
  logic             out_mbready;

  logic [3:0]       out_sbid;
  logic [1:0]       out_sbresp;
  logic [1:0]       out_sbuser;
  logic             out_sbvalid;
  logic             in_sbready;

  logic             err_id;

  modport slave (
    input  in_cid, in_ccnt, in_cvalid,
    output out_cready,
    input  in_mbid, in_mbresp, in_mbuser, in_mbvalid,
    output out_mbready,
    output out_sbid, out_sbresp, out_sbuser, out_sbvalid,
    input  in_sbready,
    output err_id
  );

  modport master (
    output in_cid, in_ccnt, in_cvalid,
    input  out_cready,
    output in_mbid, in_mbresp, in_mbuser, in_mbvalid,
    input  out_mbready,
    input  out_sbid, out_sbresp, out_sbuser, out_sbvalid,
    output in_sbready,
    input  err_id
  );
endinterface

`default_nettype wire

// File: rtl/axi_bresp_merge.sv
// ----------------------------------------------------------------------------
// axi_bresp_merge : folds the N slave B beats of one split write into one B
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_bresp_merge #(
  parameter int CMD_DEPTH = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  axi_bresp_merge_if.slave bus
);

  localparam int C_AW = $clog2(CMD_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [3:0]       r_fifo_id  [CMD_DEPTH];
  logic [CNT_W-1:0] r_fifo_cnt [CMD_DEPTH];
  logic [C_AW:0]    r_wr_ptr;
  logic [C_AW:0]    r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_beat;
  logic             w_mbready;

  logic [3:0]       r_cur_id;
  logic [CNT_W-1:0] r_remain;
  logic             r_any_dec;
  logic             r_any_slv;
  logic             r_all_ex;
  logic [1:0]       r_user;
  logic             r_err_id;
  logic [1:0]       w_resp;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                   (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
  assign w_push  = bus.in_cvalid && bus.out_cready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr[C_AW-1:0]]  <= bus.in_cid;
      r_fifo_cnt[r_wr_ptr[C_AW-1:0]] <= bus.in_ccnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (C_AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (C_AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_beat      = 1'b0;
    w_mbready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_mbready = 1'b1;
        if (bus.in_mbvalid) begin
          w_beat = 1'b1;
          if (r_remain == CNT_W'(1)) w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        // Chain straight into the next command to avoid an IDLE bubble.
        if (bus.in_sbready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_ACCUM;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_id  <= '0;
      r_remain  <= '0;
      r_any_dec <= 1'b0;
      r_any_slv <= 1'b0;
      r_all_ex  <= 1'b0;
      r_user    <= '0;
      r_err_id  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cur_id  <= r_fifo_id[r_rd_ptr[C_AW-1:0]];
        r_remain  <= (r_fifo_cnt[r_rd_ptr[C_AW-1:0]] == '0) ? CNT_W'(1)
                                                            : r_fifo_cnt[r_rd_ptr[C_AW-1:0]];
        r_any_dec <= 1'b0;
        r_any_slv <= 1'b0;
        r_all_ex  <= 1'b1;
        r_user    <= '0;
      end else if (w_beat) begin
        r_remain  <= r_remain - CNT_W'(1);
        r_any_dec <= r_any_dec || (bus.in_mbresp == 2'b11);
        r_any_slv <= r_any_slv || (bus.in_mbresp == 2'b10);
        r_all_ex  <= r_all_ex  && (bus.in_mbresp == 2'b01);
        r_user    <= bus.in_mbuser;
      end
      if (w_beat && (bus.in_mbid != r_cur_id)) r_err_id <= 1'b1;
    end
  end

  // Severity order: DECERR > SLVERR > EXOKAY (only if unanimous) > OKAY.
  always_comb begin
    w_resp = 2'b00;
    if (r_any_dec)      w_resp = 2'b11;
    else if (r_any_slv) w_resp = 2'b10;
    else if (r_all_ex)  w_resp = 2'b01;
  end

  assign bus.out_cready  = !w_full && !reset;
  assign bus.out_mbready = w_mbready;
  assign bus.out_sbvalid = (r_state == S_SEND);
  assign bus.out_sbid    = r_cur_id;
  assign bus.out_sbresp  = w_resp;
  assign bus.out_sbuser  = r_user;
  assign bus.err_id      = r_err_id;

endmodule

`default_nettype wire
